// File: rtl/sobel_frame_ctrl.sv
// Frame-level controller for the sobel engine: IM/OM port ownership, engine reset/start
// sequencing, finish detection, write-pipeline drain and done/timeout reporting.
module sobel_frame_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int DRAIN_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1 << 20,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    input  logic                   host_req_i,
    input  logic                   host_we_i,
    input  logic [ADDR_WIDTH-1:0]  host_addr_i,
    input  logic [DATA_WIDTH-1:0]  host_wdata_i,
    output logic                   host_gnt_o,
    output logic                   host_rvalid_o,
    output logic [DATA_WIDTH-1:0]  host_rdata_o,
    output logic                   eng_rst_no,
    input  logic                   eng_finish_i,
    input  logic [ADDR_WIDTH-1:0]  eng_rd_addr_i,
    output logic [DATA_WIDTH-1:0]  eng_rd_data_o,
    input  logic                   eng_wr_en_i,
    input  logic [ADDR_WIDTH-1:0]  eng_wr_addr_i,
    input  logic [DATA_WIDTH-1:0]  eng_wr_data_i,
    output logic                   im_we_o,
    output logic [ADDR_WIDTH-1:0]  im_addr_o,
    output logic [DATA_WIDTH-1:0]  im_wdata_o,
    input  logic [DATA_WIDTH-1:0]  im_rdata_i,
    output logic                   om_we_o,
    output logic [ADDR_WIDTH-1:0]  om_addr_o,
    output logic [DATA_WIDTH-1:0]  om_wdata_o,
    input  logic [DATA_WIDTH-1:0]  om_rdata_i
);

    // state | meaning
    // IDLE  | host owns IM/OM, engine held in reset, waiting for start_i
    // ARM   | one cycle: engine takes the memories, engine reset released at exit
    // RUN   | engine processing; bounded by the timeout counter
    // DRAIN | finish seen; OM writes still forwarded while the engine pipeline empties

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DR_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [DR_W-1:0]        dr_cnt_q, dr_cnt_d;
    logic                   eng_rst_n_q, eng_rst_n_d;
    logic                   timeout_q, timeout_d;
    logic                   done_q, done_d;
    logic                   rvalid_q, rvalid_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            to_cnt_q    <= '0;
            dr_cnt_q    <= '0;
            eng_rst_n_q <= 1'b0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            dr_cnt_q    <= dr_cnt_d;
            eng_rst_n_q <= eng_rst_n_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
            rvalid_q    <= rvalid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        to_cnt_d    = '0;
        dr_cnt_d    = '0;
        eng_rst_n_d = eng_rst_n_q;
        timeout_d   = timeout_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        rvalid_d    = host_req_i && !host_we_i && (state_q == S_IDLE);
        case (state_q)
            S_IDLE: begin
                eng_rst_n_d = 1'b0;
                if (start_i) begin
                    state_d   = S_ARM;
                    timeout_d = 1'b0;
                end
            end
            S_ARM: begin
                eng_rst_n_d = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                // A finish on the last allowed cycle still counts as a completed frame.
                if (eng_finish_i) begin
                    state_d = S_DRAIN;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = S_IDLE;
                    timeout_d   = 1'b1;
                    eng_rst_n_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_DRAIN: begin
                if (dr_cnt_q == DR_LAST) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    eng_rst_n_d = 1'b0;
                end else begin
                    dr_cnt_d = dr_cnt_q + DR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (state_q != S_IDLE);
        host_gnt_o    = host_req_i && (state_q == S_IDLE);
        done_o        = done_q;
        timeout_o     = timeout_q;
        frame_cnt_o   = frame_cnt_q;
        eng_rst_no    = eng_rst_n_q;
        host_rvalid_o = rvalid_q;
        host_rdata_o  = om_rdata_i;
        eng_rd_data_o = im_rdata_i;
        im_wdata_o    = host_wdata_i;
        om_wdata_o    = eng_wr_data_i;
        if (state_q == S_IDLE) begin
            im_we_o   = host_req_i && host_we_i;
            im_addr_o = host_addr_i;
            om_we_o   = 1'b0;
            om_addr_o = host_addr_i;
        end else begin
            im_we_o   = 1'b0;
            im_addr_o = eng_rd_addr_i;
            om_we_o   = eng_wr_en_i;
            om_addr_o = eng_wr_addr_i;
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl: behavioural IM/OM contents and frame/done timing model,
// randomized engine stub and host traffic, monitor compares every DUT response it sees.
module tb_sobel_frame_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int DRAIN = 2;
    localparam int TMO   = 128;
    localparam int FW    = 16;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          rst_ni, start_i, busy_o, done_o, timeout_o;
    logic [FW-1:0] frame_cnt_o;
    logic          host_req_i, host_we_i, host_gnt_o, host_rvalid_o;
    logic [AW-1:0] host_addr_i;
    logic [DW-1:0] host_wdata_i, host_rdata_o;
    logic          eng_rst_no, eng_finish_i, eng_wr_en_i;
    logic [AW-1:0] eng_rd_addr_i, eng_wr_addr_i;
    logic [DW-1:0] eng_rd_data_o, eng_wr_data_i;
    logic          im_we_o, om_we_o;
    logic [AW-1:0] im_addr_o, om_addr_o;
    logic [DW-1:0] im_wdata_o, om_wdata_o, im_rdata_i, om_rdata_i;

    sobel_frame_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DRAIN_CYCLES(DRAIN),
        .TIMEOUT_CYCLES(TMO), .FRAME_CNT_W(FW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .timeout_o(timeout_o), .frame_cnt_o(frame_cnt_o), .host_req_i(host_req_i),
        .host_we_i(host_we_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
        .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
        .eng_rst_no(eng_rst_no), .eng_finish_i(eng_finish_i), .eng_rd_addr_i(eng_rd_addr_i),
        .eng_rd_data_o(eng_rd_data_o), .eng_wr_en_i(eng_wr_en_i), .eng_wr_addr_i(eng_wr_addr_i),
        .eng_wr_data_i(eng_wr_data_i), .im_we_o(im_we_o), .im_addr_o(im_addr_o),
        .im_wdata_o(im_wdata_o), .im_rdata_i(im_rdata_i), .om_we_o(om_we_o),
        .om_addr_o(om_addr_o), .om_wdata_o(om_wdata_o), .om_rdata_i(om_rdata_i)
    );

    // Synchronous 1-cycle-latency memories attached to the DUT ports.
    bit [DW-1:0] im_mem [0:65535];
    bit [DW-1:0] om_mem [0:65535];
    always @(posedge clk_i) begin
        if (im_we_o) im_mem[im_addr_o] <= im_wdata_o;
        if (om_we_o) om_mem[om_addr_o] <= om_wdata_o;
        im_rdata_i <= im_mem[im_addr_o];
        om_rdata_i <= om_mem[om_addr_o];
    end

    // Reference contents of what each memory should hold.
    bit [DW-1:0] ref_im [0:65535];
    bit [DW-1:0] ref_om [0:65535];

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {int cyc; logic [DW-1:0] data;} rd_exp_t;
    typedef struct {int cyc; int cnt;} done_exp_t;
    rd_exp_t       q_eng[$];
    logic [DW-1:0] q_host[$];
    done_exp_t     q_done[$];

    int n_vec = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (host_rvalid_o) begin
                if (q_host.size() == 0) chk("host_rvalid_unexpected", 1, 0);
                else chk("host_rdata", host_rdata_o, q_host.pop_front());
            end
            if (q_eng.size() != 0 && q_eng[0].cyc == cyc) begin
                rd_exp_t e;
                e = q_eng.pop_front();
                chk("eng_rd_data", eng_rd_data_o, e.data);
            end
            if (q_done.size() != 0 && q_done[0].cyc < cyc) begin
                void'(q_done.pop_front());
                chk("done_missing", 0, 1);
            end
            if (done_o) begin
                if (q_done.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    done_exp_t d;
                    d = q_done.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("frame_cnt_at_done", 32'(frame_cnt_o), d.cnt);
                    chk("busy_at_done", busy_o, 0);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_eng();
        eng_finish_i = 0; eng_wr_en_i = 0; start_i = 0; host_req_i = 0; host_we_i = 0;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_req_i = 1; host_we_i = 1; host_addr_i = a; host_wdata_i = d;
        #1 chk("host_gnt_idle_wr", host_gnt_o, 1);
        ref_im[a] = d;
        tick();
        host_req_i = 0; host_we_i = 0;
    endtask

    task automatic host_read(input logic [AW-1:0] a);
        host_req_i = 1; host_we_i = 0; host_addr_i = a;
        #1 chk("host_gnt_idle_rd", host_gnt_o, 1);
        q_host.push_back(ref_om[a]);
        tick();
        host_req_i = 0;
    endtask

    // One frame. fin_at = RUN cycle index of the finish pulse; timeout frames never finish.
    task automatic run_frame(input int fin_at, input bit do_to, input bit host_with_start);
        int w;
        int last;
        bit active;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        start_i = 1;
        if (host_with_start) begin
            host_req_i = 1; host_we_i = 1; host_addr_i = 16'h0020; host_wdata_i = 8'h77;
            #1 chk("gnt_with_start", host_gnt_o, 1);
            ref_im[16'h0020] = 8'h77;
        end
        tick();
        clear_eng();
        chk("timeout_cleared_on_start", timeout_o, 0);
        chk("busy_in_arm", busy_o, 1);
        w = 0;
        while (!eng_rst_no && w < 8) begin
            tick();
            w++;
        end
        chk("eng_rst_release", eng_rst_no, 1);
        last = do_to ? TMO + 1 : fin_at + DRAIN + 1;
        for (int i = 0; i <= last; i++) begin
            active = do_to ? (i < TMO) : (i <= fin_at + DRAIN);
            clear_eng();
            if (!do_to && i == fin_at) begin
                eng_finish_i = 1;
                exp_cnt++;
                q_done.push_back('{cyc: cyc + DRAIN + 1, cnt: exp_cnt});
            end
            if (!do_to && i > fin_at && i <= fin_at + DRAIN) eng_finish_i = 1'($urandom_range(0, 1));
            if (active && $urandom_range(0, 2) == 0) begin
                a = 16'h0010 + 16'($urandom_range(0, 16));
                eng_rd_addr_i = a;
                q_eng.push_back('{cyc: cyc + 1, data: ref_im[a]});
            end
            if (active && $urandom_range(0, 3) == 0) begin
                a = 16'($urandom_range(0, 15)); d = 8'($urandom);
                eng_wr_en_i = 1; eng_wr_addr_i = a; eng_wr_data_i = d;
                ref_om[a] = d;
            end
            if (!do_to && i == fin_at + 1 && exp_cnt == 1) begin
                eng_wr_en_i = 1; eng_wr_addr_i = 16'h0003; eng_wr_data_i = 8'hFF;
                ref_om[16'h0003] = 8'hFF;
            end
            if (!active) begin
                // engine write after the frame has ended must not reach OM
                eng_wr_en_i = 1; eng_wr_addr_i = 16'($urandom_range(0, 15)); eng_wr_data_i = 8'($urandom);
            end
            if (active && $urandom_range(0, 4) == 0) begin
                host_req_i = 1; host_we_i = 1;
                host_addr_i = 16'h0010 + 16'($urandom_range(0, 16));
                host_wdata_i = 8'($urandom);
                start_i = 1'($urandom_range(0, 1));
            end
            #1;
            if (host_req_i) chk("host_gnt_busy", host_gnt_o, 0);
            if (do_to && i == TMO - 1) chk("busy_last_run", busy_o, 1);
            if (do_to && i == TMO) begin
                chk("timeout_busy", busy_o, 0);
                chk("timeout_flag", timeout_o, 1);
                chk("timeout_eng_rst", eng_rst_no, 0);
                chk("timeout_frame_cnt", 32'(frame_cnt_o), exp_cnt);
            end
            if (!do_to && i == last) chk("eng_rst_after_done", eng_rst_no, 0);
            tick();
        end
        clear_eng();
        tick();
    endtask

    task automatic read_back();
        host_read(16'h0003);
        for (int k = 0; k < 5; k++) host_read(16'($urandom_range(0, 15)));
        tick();
        tick();
    endtask

    initial begin
        rst_ni = 0; start_i = 0; host_req_i = 1; host_we_i = 0; host_addr_i = '0; host_wdata_i = '0;
        eng_finish_i = 0; eng_rd_addr_i = '0; eng_wr_en_i = 0; eng_wr_addr_i = '0; eng_wr_data_i = '0;
        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_frame_cnt", 32'(frame_cnt_o), 0);
        chk("rst_rvalid", host_rvalid_o, 0);
        chk("rst_eng_rst", eng_rst_no, 0);
        chk("rst_gnt_follows_req1", host_gnt_o, 1);
        host_req_i = 0;
        #1 chk("rst_gnt_follows_req0", host_gnt_o, 0);
        tick();
        rst_ni = 1;
        tick();

        host_write(16'h0010, 8'h5A);
        for (int k = 1; k < 16; k++) host_write(16'h0010 + 16'(k), 8'($urandom));

        run_frame(100, 0, 0);
        read_back();
        run_frame(0, 0, 0);
        read_back();
        run_frame(TMO - 1, 0, 0);
        read_back();
        run_frame(0, 1, 0);
        chk("timeout_sticky", timeout_o, 1);
        read_back();
        run_frame(int'($urandom_range(1, 60)), 0, 1);
        read_back();
        for (int f = 0; f < 3; f++) begin
            run_frame(int'($urandom_range(0, TMO - 1)), 0, 0);
            read_back();
        end
        chk("frame_cnt_final", 32'(frame_cnt_o), exp_cnt);

        // Reset in the middle of RUN aborts the frame silently.
        start_i = 1;
        tick();
        start_i = 0;
        repeat (6) tick();
        chk("busy_before_midreset", busy_o, 1);
        rst_ni = 0;
        repeat (2) tick();
        chk("midreset_busy", busy_o, 0);
        chk("midreset_eng_rst", eng_rst_no, 0);
        chk("midreset_frame_cnt", 32'(frame_cnt_o), 0);
        rst_ni = 1;
        repeat (10) tick();
        chk("midreset_no_done", done_o, 0);

        chk("q_done_empty", q_done.size(), 0);
        chk("q_host_empty", q_host.size(), 0);
        chk("q_eng_empty", q_eng.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
